// File: rtl/roi_pool_capture_ctrl.sv
// ROI max-pool capture controller: arms on request, waits for frame start,
// max-pools a fixed ROI into an OUT_DIM x OUT_DIM image and writes it row-major
// to the classifier input buffer, then holds DONE until acknowledged.
module roi_pool_capture_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ROI_X0   = 180,
    parameter int unsigned ROI_Y0   = 100,
    parameter int unsigned POOL     = 10,
    parameter int unsigned OUT_DIM  = 28
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iSTART,
    input  logic       iFRAME_START,
    input  logic       iPIX_VALID,
    input  logic [7:0] iPIX,
    output logic       oWR_EN,
    output logic [9:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oBUSY,
    output logic       oDONE,
    input  logic       iACK
);

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned XW        = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW        = $clog2(V_ACTIVE + 1);
    localparam int unsigned CW        = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned ROI_W     = POOL * OUT_DIM;
    localparam int unsigned LAST_ADDR = OUT_DIM * OUT_DIM - 1;

    localparam logic [XW-1:0]     X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0]     X_LO    = XW'(ROI_X0);
    localparam logic [XW-1:0]     X_HI    = XW'(ROI_X0 + ROI_W);
    localparam logic [YW-1:0]     Y_LO    = YW'(ROI_Y0);
    localparam logic [YW-1:0]     Y_HI    = YW'(ROI_Y0 + ROI_W);
    localparam logic [XW-1:0]     PX_LAST = XW'(POOL - 1);
    localparam logic [YW-1:0]     PY_LAST = YW'(POOL - 1);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Pixel coordinates plus position within the pooling grid (sub = offset in
    // window, blk = window index); blk/sub are only meaningful inside the ROI.
    logic [XW-1:0] x_q, x_d, xs_q, xs_d, xb_q, xb_d;
    logic [YW-1:0] y_q, y_d, ys_q, ys_d, yb_q, yb_d;

    logic [DATA_W-1:0] acc_q [OUT_DIM];
    logic [DATA_W-1:0] acc_d [OUT_DIM];

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fs_c;
    logic [XW-1:0]     px_c, pxs_c, pxb_c;
    logic [YW-1:0]     py_c, pys_c, pyb_c;
    logic              line_end_c;
    logic              in_roi_c;
    logic              blk_end_c;
    logic              restart_c;
    logic              proc_c;
    logic              wr_fire_c;
    logic              done_go_c;
    logic [CW-1:0]     col_c;
    logic [DATA_W-1:0] acc_cur_c;
    logic [DATA_W-1:0] pool_max_c;

    // Effective coordinates of the current pixel; frame start forces (0,0).
    always_comb begin
        fs_c  = iFRAME_START & iPIX_VALID;
        px_c  = fs_c ? '0 : x_q;
        pxs_c = fs_c ? '0 : xs_q;
        pxb_c = fs_c ? '0 : xb_q;
        py_c  = fs_c ? '0 : y_q;
        pys_c = fs_c ? '0 : ys_q;
        pyb_c = fs_c ? '0 : yb_q;
    end

    // Coordinate and pooling-grid advance on each valid pixel.
    always_comb begin
        x_d        = x_q;
        xs_d       = xs_q;
        xb_d       = xb_q;
        y_d        = y_q;
        ys_d       = ys_q;
        yb_d       = yb_q;
        line_end_c = (px_c == X_LAST);
        if (iPIX_VALID) begin
            x_d = line_end_c ? '0 : px_c + XW'(1);
            if (x_d == X_LO) begin
                xs_d = '0;
                xb_d = '0;
            end else if (pxs_c == PX_LAST) begin
                xs_d = '0;
                xb_d = pxb_c + XW'(1);
            end else begin
                xs_d = pxs_c + XW'(1);
                xb_d = pxb_c;
            end
            if (line_end_c) begin
                y_d = (py_c == Y_LAST) ? '0 : py_c + YW'(1);
                if (y_d == Y_LO) begin
                    ys_d = '0;
                    yb_d = '0;
                end else if (pys_c == PY_LAST) begin
                    ys_d = '0;
                    yb_d = pyb_c + YW'(1);
                end else begin
                    ys_d = pys_c + YW'(1);
                    yb_d = pyb_c;
                end
            end else begin
                y_d  = py_c;
                ys_d = pys_c;
                yb_d = pyb_c;
            end
        end
    end

    // Pooling datapath: column max accumulators and write generation.
    always_comb begin
        done_go_c  = (state_q == S_CAPTURE) && wr_en_q && (wr_addr_q == A_LAST);
        restart_c  = fs_c && ((state_q == S_ARM) || (state_q == S_CAPTURE));
        proc_c     = iPIX_VALID && !done_go_c &&
                     ((state_q == S_CAPTURE) || ((state_q == S_ARM) && fs_c));
        in_roi_c   = (px_c >= X_LO) && (px_c < X_HI) && (py_c >= Y_LO) && (py_c < Y_HI);
        blk_end_c  = (pxs_c == PX_LAST) && (pys_c == PY_LAST);
        col_c      = pxb_c[CW-1:0];
        acc_cur_c  = restart_c ? '0 : acc_q[col_c];
        pool_max_c = (iPIX > acc_cur_c) ? iPIX : acc_cur_c;
        wr_fire_c  = proc_c && in_roi_c && blk_end_c;

        acc_d = acc_q;
        if (restart_c) begin
            for (int unsigned i = 0; i < OUT_DIM; i++) begin
                acc_d[i] = '0;
            end
        end
        if (proc_c && in_roi_c) begin
            acc_d[col_c] = blk_end_c ? '0 : pool_max_c;
        end

        wr_en_d   = wr_fire_c;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_fire_c) begin
            wr_addr_d = ADDR_W'(32'(pyb_c) * OUT_DIM + 32'(pxb_c));
            wr_data_d = pool_max_c;
        end
    end

    // FSM state register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (iSTART) state_d = S_ARM;
            S_ARM:     if (fs_c) state_d = S_CAPTURE;
            S_CAPTURE: if (done_go_c) state_d = S_DONE;
            S_DONE:    if (iACK) state_d = iSTART ? S_ARM : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM status outputs, decoded from the next state and registered.
    always_comb begin
        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    // Datapath, accumulator and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            x_q       <= '0;
            xs_q      <= '0;
            xb_q      <= '0;
            y_q       <= '0;
            ys_q      <= '0;
            yb_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < OUT_DIM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            x_q       <= x_d;
            xs_q      <= xs_d;
            xb_q      <= xb_d;
            y_q       <= y_d;
            ys_q      <= ys_d;
            yb_q      <= yb_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int unsigned i = 0; i < OUT_DIM; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign oWR_EN   = wr_en_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;

endmodule

// File: tb/tb_roi_pool_capture_ctrl.sv
// Bench for roi_pool_capture_ctrl on a reduced 20x16 frame with a 12x12 ROI
// pooled 3x3 into a 4x4 image (16 buffer writes per capture).
module tb_roi_pool_capture_ctrl;

    localparam int H  = 20;
    localparam int V  = 16;
    localparam int X0 = 5;
    localparam int Y0 = 2;
    localparam int P  = 3;
    localparam int N  = 4;
    localparam int NW = N * N;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iSTART = 1'b0;
    logic       iFRAME_START = 1'b0;
    logic       iPIX_VALID = 1'b0;
    logic [7:0] iPIX = 8'h00;
    logic       iACK = 1'b0;
    logic       oWR_EN;
    logic [9:0] oWR_ADDR;
    logic [7:0] oWR_DATA;
    logic       oBUSY;
    logic       oDONE;

    roi_pool_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ROI_X0(X0), .ROI_Y0(Y0), .POOL(P), .OUT_DIM(N)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iFRAME_START(iFRAME_START),
        .iPIX_VALID(iPIX_VALID), .iPIX(iPIX), .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR),
        .oWR_DATA(oWR_DATA), .oBUSY(oBUSY), .oDONE(oDONE), .iACK(iACK)
    );

    always #5 iCLK = ~iCLK;

    int tests = 0;
    int fails = 0;

    // Write/done monitor, sampled on the falling edge.
    int cyc = 0;
    int mon_addr[$];
    int mon_data[$];
    int last_wr_cyc = -1;
    int done_rise_cyc = -1;
    logic done_prev = 1'b0;

    always @(negedge iCLK) begin
        cyc = cyc + 1;
        if (oWR_EN === 1'b1) begin
            mon_addr.push_back(int'(oWR_ADDR));
            mon_data.push_back(int'(oWR_DATA));
            last_wr_cyc = cyc;
        end
        if (oDONE === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = oDONE;
    end

    typedef struct {
        int bg;
        int hx;
        int hy;
        int hv;
        bit rnd;
        int exp_addr;
        int exp_hot;
        int exp_other;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [7:0] pixval(input int x, input int y, input int bg,
                                          input int hx, input int hy, input int hv);
        if (x == hx && y == hy) return 8'(hv);
        if (x >= X0 && x < X0 + P * N && y >= Y0 && y < Y0 + P * N) return 8'(bg);
        return 8'h00;
    endfunction

    task automatic drive_pixel(input bit fs, input logic [7:0] v, input bit rnd);
        if (rnd) begin
            for (int k = 0; k < 4 && $urandom_range(1, 0) == 0; k++) begin
                iPIX_VALID   = 1'b0;
                iFRAME_START = 1'b0;
                iPIX         = 8'($urandom);
                tick();
            end
        end
        iPIX_VALID   = 1'b1;
        iFRAME_START = fs;
        iPIX         = v;
        tick();
        iPIX_VALID   = 1'b0;
        iFRAME_START = 1'b0;
    endtask

    // Sends rows 0..nrows-1 of a frame; stray iSTART+iACK on pixel index stray.
    task automatic send_rows(input int nrows, input int bg, input int hx, input int hy,
                             input int hv, input bit rnd, input int stray);
        for (int y = 0; y < nrows; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y * H + x == stray) begin
                    iSTART = 1'b1;
                    iACK   = 1'b1;
                end
                drive_pixel(x == 0 && y == 0, pixval(x, y, bg, hx, hy, hv), rnd);
                iSTART = 1'b0;
                iACK   = 1'b0;
            end
        end
        tick();
        tick();
    endtask

    task automatic pulse_start();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
    endtask

    task automatic pulse_ack();
        iACK = 1'b1;
        tick();
        iACK = 1'b0;
        tick();
        check("ack_done_low", int'(oDONE), 0);
        check("ack_busy_low", int'(oBUSY), 0);
    endtask

    // Checks the writes recorded since index base and the DONE handshake.
    task automatic check_capture(input string tag, input int base, input int done_before,
                                 input int exp_addr, input int exp_hot, input int exp_other);
        int cnt;
        int e;
        cnt = mon_addr.size() - base;
        check({tag, "_wr_count"}, cnt, NW);
        for (int i = 0; i < cnt && i < NW; i++) begin
            e = (i == exp_addr) ? exp_hot : exp_other;
            check($sformatf("%s_addr%0d", tag, i), mon_addr[base + i], i);
            check($sformatf("%s_data%0d", tag, i), mon_data[base + i], e);
        end
        check({tag, "_done_rose"}, int'(done_rise_cyc != done_before), 1);
        check({tag, "_done_lat"}, done_rise_cyc - last_wr_cyc, 1);
        check({tag, "_done"}, int'(oDONE), 1);
        check({tag, "_busy"}, int'(oBUSY), 0);
    endtask

    initial begin
        int base;
        int dsave;

        vecs[0]  = '{'h80, -1, -1, 0, 1'b0, -1, 0, 'h80};
        vecs[1]  = '{0, X0 + 4, Y0 + 7, 'hFF, 1'b0, 9, 'hFF, 0};
        vecs[2]  = '{0, X0, Y0, 'h11, 1'b0, 0, 'h11, 0};
        vecs[3]  = '{0, X0 + 11, Y0 + 11, 'h7E, 1'b0, 15, 'h7E, 0};
        vecs[4]  = '{0, X0 + 11, Y0, 'h44, 1'b0, 3, 'h44, 0};
        vecs[5]  = '{0, X0, Y0 + 11, 'h55, 1'b0, 12, 'h55, 0};
        vecs[6]  = '{'h40, X0 + 5, Y0 + 2, 'hFF, 1'b0, 1, 'hFF, 'h40};
        vecs[7]  = '{'h90, X0 + 8, Y0 + 4, 'h20, 1'b0, -1, 0, 'h90};
        vecs[8]  = '{0, X0 - 1, Y0, 'hFF, 1'b0, -1, 0, 0};
        vecs[9]  = '{0, X0 + 12, Y0 + 5, 'hFF, 1'b0, -1, 0, 0};
        vecs[10] = '{0, X0 + 2, Y0 + 12, 'hFF, 1'b0, -1, 0, 0};
        vecs[11] = '{'h80, -1, -1, 0, 1'b1, -1, 0, 'h80};
        vecs[12] = '{0, X0 + 4, Y0 + 7, 'hFF, 1'b1, 9, 'hFF, 0};
        vecs[13] = '{0, X0 + 2, Y0 + 2, 'h66, 1'b0, 0, 'h66, 0};

        // Reset values
        tick();
        tick();
        check("rst_wr_en", int'(oWR_EN), 0);
        check("rst_addr", int'(oWR_ADDR), 0);
        check("rst_data", int'(oWR_DATA), 0);
        check("rst_busy", int'(oBUSY), 0);
        check("rst_done", int'(oDONE), 0);
        iRST_N = 1'b1;
        tick();

        // Table of full captures
        foreach (vecs[v]) begin
            base  = mon_addr.size();
            dsave = done_rise_cyc;
            pulse_start();
            check($sformatf("v%0d_arm_busy", v), int'(oBUSY), 1);
            send_rows(V, vecs[v].bg, vecs[v].hx, vecs[v].hy, vecs[v].hv, vecs[v].rnd, -1);
            check_capture($sformatf("v%0d", v), base, dsave,
                          vecs[v].exp_addr, vecs[v].exp_hot, vecs[v].exp_other);
            pulse_ack();
        end

        // Restart mid-capture with stray iSTART/iACK; stale accumulators must clear
        base = mon_addr.size();
        pulse_start();
        send_rows(10, 'hFF, -1, -1, 0, 1'b0, 3 * H + 2);
        check("rs_partial_count", mon_addr.size() - base, 8);
        check("rs_partial_busy", int'(oBUSY), 1);
        check("rs_partial_done", int'(oDONE), 0);
        base  = mon_addr.size();
        dsave = done_rise_cyc;
        send_rows(V, 'h10, -1, -1, 0, 1'b0, -1);
        check_capture("rs", base, dsave, -1, 0, 'h10);
        pulse_ack();

        // Async reset mid-capture
        pulse_start();
        send_rows(6, 'h80, -1, -1, 0, 1'b0, -1);
        check("ar_pre_addr", int'(oWR_ADDR), 3);
        check("ar_pre_data", int'(oWR_DATA), 'h80);
        check("ar_pre_busy", int'(oBUSY), 1);
        #2;
        iRST_N = 1'b0;
        #1;
        check("ar_wr_en", int'(oWR_EN), 0);
        check("ar_addr", int'(oWR_ADDR), 0);
        check("ar_data", int'(oWR_DATA), 0);
        check("ar_busy", int'(oBUSY), 0);
        check("ar_done", int'(oDONE), 0);
        tick();
        tick();
        iRST_N = 1'b1;
        tick();
        base = mon_addr.size();
        send_rows(V, 'h80, -1, -1, 0, 1'b0, -1);
        check("ar_no_writes", mon_addr.size() - base, 0);
        check("ar_idle_busy", int'(oBUSY), 0);

        // DONE held across frames, then ACK+START re-arms
        base  = mon_addr.size();
        dsave = done_rise_cyc;
        pulse_start();
        send_rows(V, 'h80, -1, -1, 0, 1'b0, -1);
        check_capture("hd", base, dsave, -1, 0, 'h80);
        base = mon_addr.size();
        for (int f = 0; f < 3; f++) send_rows(V, 'hFF, -1, -1, 0, 1'b0, -1);
        check("hd_no_writes", mon_addr.size() - base, 0);
        check("hd_done_held", int'(oDONE), 1);
        iACK   = 1'b1;
        iSTART = 1'b1;
        tick();
        iACK   = 1'b0;
        iSTART = 1'b0;
        check("hd_rearm_busy", int'(oBUSY), 1);
        check("hd_rearm_done", int'(oDONE), 0);
        base  = mon_addr.size();
        dsave = done_rise_cyc;
        send_rows(V, 'h22, -1, -1, 0, 1'b0, -1);
        check_capture("hd2", base, dsave, -1, 0, 'h22);
        pulse_ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
